pixel_unpacker: RTL and testbench

Downstream consumer of the DMA read stream (mm2s): accepts 64-bit little-endian memory words holding packed RGB888 frame data and emits one 24-bit pixel per handshake. Tracks raster position and marks start-of-frame, end-of-line and end-of-frame, so the accelerator sees a framed pixel stream instead of raw bus words. Sits between the DMA's mm2s output and the accelerator's pixel input, in the DMA clock domain.

---
 rtl/pixel_unpacker_pkg.sv | 24 ++
 rtl/pixel_unpacker_pos_counter.sv | 53 +++++
 rtl/pixel_unpacker.sv | 112 +++++++++++
 tb/tb_pixel_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_unpacker_pkg.sv
// ============================================================================
// Module  : pixel_unpacker_pkg
// Brief   : Shared byte-count constants and pixel type for pixel_unpacker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_unpacker_pkg;

    localparam int WORD_BYTES = 8;
    localparam int PIX_BYTES  = 3;
    localparam int BUF_BYTES  = 16;
    localparam int CNT_W      = 5;

    typedef logic [8*PIX_BYTES-1:0] pixel_t;

    // Reverses byte order so the first memory byte lands in the top byte.
    function automatic pixel_t swap_rgb(input pixel_t p);
        return {p[7:0], p[15:8], p[23:16]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_unpacker_pos_counter.sv
// ============================================================================
// Module  : pix_pos_counter
// Brief   : Raster x/y position with start-of-frame / end-of-line / end-of-frame
//           decode, advanced once per consumed pixel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_pos_counter
    import pixel_unpacker_pkg::*;
#(
    parameter int H_RES = 1280,
    parameter int V_RES = 720
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_clr,
    input  logic advance,
    output logic sof,
    output logic eol,
    output logic eof
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    assign sof = (r_x == '0) && (r_y == '0);
    assign eol = (r_x == X_W'(H_RES - 1));
    assign eof = eol && (r_y == Y_W'(V_RES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (sync_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (advance) begin
            if (eol) begin
                r_x <= '0;
                r_y <= eof ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_unpacker.sv
// ============================================================================
// Module  : pixel_unpacker
// Brief   : Unpacks 64-bit little-endian RGB888 memory words into a framed
//           24-bit pixel stream. Define PIXEL_UNPACKER_BGR_SWAP_EN to place the
//           first memory byte in pix_data[23:16].
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int H_RES = 1280,
    parameter int V_RES = 720
) (
    input  logic        m_axi_acp_aclk,
    input  logic        axi_reset,
    input  logic        sync_clr,
    input  logic [63:0] mm2s_data,
    input  logic        mm2s_valid,
    output logic        mm2s_ready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        frame_done
);

    localparam int BUF_W = 8 * BUF_BYTES;
    localparam int PAD_W = 8 * (BUF_BYTES - WORD_BYTES);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_base;
    logic [7:0]       w_shift;
    logic [BUF_W-1:0] w_word_ext;
    logic [BUF_W-1:0] w_mask;
    logic [BUF_W-1:0] w_buf_shift;
    logic [BUF_W-1:0] w_buf_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_sof;
    logic             w_eol;
    logic             w_eof;
    pixel_t           w_pixel;

    // Both handshake readiness flags come from the fill count only.
    assign mm2s_ready = (r_cnt <= CNT_W'(WORD_BYTES));
    assign pix_valid  = (r_cnt >= CNT_W'(PIX_BYTES));

    assign w_push = mm2s_valid & mm2s_ready;
    assign w_pop  = pix_valid & pix_ready;

    // New word lands right after the bytes that survive this cycle's pop.
    assign w_base      = r_cnt - (w_pop ? CNT_W'(PIX_BYTES) : CNT_W'(0));
    assign w_shift     = {w_base, 3'b000};
    assign w_word_ext  = {{PAD_W{1'b0}}, mm2s_data} << w_shift;
    assign w_mask      = {{PAD_W{1'b0}}, {(8*WORD_BYTES){1'b1}}} << w_shift;
    assign w_buf_shift = w_pop ? (r_buf >> (8 * PIX_BYTES)) : r_buf;
    assign w_buf_next  = w_push ? ((w_buf_shift & ~w_mask) | w_word_ext) : w_buf_shift;
    assign w_cnt_next  = r_cnt + (w_push ? CNT_W'(WORD_BYTES) : CNT_W'(0))
                               - (w_pop  ? CNT_W'(PIX_BYTES)  : CNT_W'(0));

    always_ff @(posedge m_axi_acp_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (sync_clr) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_buf        <= w_buf_next;
            r_cnt        <= w_cnt_next;
            r_frame_done <= w_pop & w_eof;
        end
    end

    pix_pos_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_pos (
        .clk      (m_axi_acp_aclk),
        .rst      (axi_reset),
        .sync_clr (sync_clr),
        .advance  (w_pop),
        .sof      (w_sof),
        .eol      (w_eol),
        .eof      (w_eof)
    );

    assign w_pixel = r_buf[8*PIX_BYTES-1:0];

`ifdef PIXEL_UNPACKER_BGR_SWAP_EN
    assign pix_data = swap_rgb(w_pixel);
`else
    assign pix_data = w_pixel;
`endif

    assign pix_sof    = pix_valid & w_sof;
    assign pix_eol    = pix_valid & w_eol;
    assign pix_eof    = pix_valid & w_eof;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
// ============================================================================
// Module  : tb_pixel_unpacker
// Brief   : Self-checking bench: directed vector table, hand sequences for
//           flush/reset/frame corners, random traffic against a byte-queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_unpacker;

    localparam int H    = 8;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        sync_clr = 1'b0;
    logic [63:0] mm2s_data = '0;
    logic        mm2s_valid = 1'b0;
    logic        mm2s_ready;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic        frame_done;

    pixel_unpacker #(.H_RES(H), .V_RES(V)) dut (
        .m_axi_acp_aclk (clk),
        .axi_reset      (axi_reset),
        .sync_clr       (sync_clr),
        .mm2s_data      (mm2s_data),
        .mm2s_valid     (mm2s_valid),
        .mm2s_ready     (mm2s_ready),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .pix_eof        (pix_eof),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ord(input logic [23:0] p);
`ifdef PIXEL_UNPACKER_BGR_SWAP_EN
        return {p[7:0], p[15:8], p[23:16]};
`else
        return p;
`endif
    endfunction

    // Reference model: memory bytes in arrival order, plus frame pixel index.
    logic [7:0]  q[$];
    int          pidx = 0;
    logic        exp_fd = 1'b0;
    bit          mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data = '0;
    int          n_sof = 0, n_eol = 0, n_eof = 0, n_fd = 0;
    logic        m_ev, m_er, m_push, m_pop;

    always @(negedge clk) begin
        if (mon_en && !axi_reset) begin
            m_ev = (q.size() >= 3);
            m_er = (q.size() <= 8);
            chk("mm2s_ready", mm2s_ready, m_er);
            chk("pix_valid", pix_valid, m_ev);
            chk("frame_done", frame_done, exp_fd);
            if (m_ev) begin
                chk("pix_data", pix_data, ord({q[2], q[1], q[0]}));
                chk("pix_sof", pix_sof, pidx == 0);
                chk("pix_eol", pix_eol, (pidx % H) == H - 1);
                chk("pix_eof", pix_eof, pidx == NPIX - 1);
                if (prev_stall) chk("stall_hold", pix_data, prev_data);
            end
            if (frame_done) n_fd++;
            m_push     = mm2s_valid && m_er && !sync_clr;
            m_pop      = m_ev && pix_ready && !sync_clr;
            prev_stall = m_ev && !pix_ready && !sync_clr;
            prev_data  = pix_data;
            if (sync_clr) begin
                q.delete();
                pidx   = 0;
                exp_fd = 1'b0;
            end else begin
                exp_fd = 1'b0;
                if (m_pop) begin
                    if (pix_sof) n_sof++;
                    if (pix_eol) n_eol++;
                    if (pix_eof) n_eof++;
                    repeat (3) void'(q.pop_front());
                    exp_fd = (pidx == NPIX - 1);
                    pidx   = (pidx + 1) % NPIX;
                end
                if (m_push)
                    for (int k = 0; k < 8; k++) q.push_back(mm2s_data[8*k +: 8]);
            end
        end
    end

    task automatic do_reset();
        mon_en     = 1'b0;
        axi_reset  = 1'b1;
        mm2s_valid = 1'b0;
        mm2s_data  = '0;
        sync_clr   = 1'b0;
        pix_ready  = 1'b0;
        #1;
        chk("rst_mm2s_ready", mm2s_ready, 1'b1);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 24'h0);
        chk("rst_flags", {pix_sof, pix_eol, pix_eof}, 3'b000);
        chk("rst_frame_done", frame_done, 1'b0);
        q.delete();
        pidx = 0; exp_fd = 1'b0; prev_stall = 1'b0;
        n_sof = 0; n_eol = 0; n_eof = 0; n_fd = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        axi_reset = 1'b0;
        mon_en    = 1'b1;
    endtask

    task automatic apply(input logic v, input logic [63:0] d, input logic r, input logic s);
        mm2s_valid = v;
        mm2s_data  = d;
        pix_ready  = r;
        sync_clr   = s;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            apply(1'b0, 64'h0, 1'b1, 1'b0);
            adv();
        end
    endtask

    // Streams words with random valid/ready, holding each word until accepted.
    task automatic stream(input int nwords, input int vp, input int rp, input bit seq);
        int sent = 0;
        int cyc = 0;
        logic acc;
        logic [7:0] sb = 8'h00;
        mm2s_valid = 1'b0;
        while (sent < nwords && cyc < 20000) begin
            if (!mm2s_valid && ($urandom_range(99) < vp)) begin
                mm2s_valid = 1'b1;
                if (seq) for (int k = 0; k < 8; k++) mm2s_data[8*k +: 8] = sb + 8'(k);
                else     mm2s_data = {$urandom, $urandom};
            end
            pix_ready = ($urandom_range(99) < rp);
            @(negedge clk);
            acc = mm2s_valid && mm2s_ready;
            adv();
            cyc++;
            if (acc) begin
                sent++;
                sb = sb + 8'd8;
                mm2s_valid = 1'b0;
            end
        end
        mm2s_valid = 1'b0;
        chk("stream_words_sent", sent, nwords);
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        r;
        logic        ev;
        logic [23:0] ed;
        logic        erdy;
    } vec_t;

    localparam logic [63:0] W0 = 64'h0706050403020100;
    localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] W2 = 64'h1716151413121110;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, W0,    1'b1, 1'b0, 24'h000000, 1'b1};
        tbl[1] = '{1'b0, 64'h0, 1'b1, 1'b1, 24'h020100, 1'b1};
        tbl[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 24'h050403, 1'b1};
        tbl[3] = '{1'b1, W1,    1'b1, 1'b0, 24'h000000, 1'b1};
        tbl[4] = '{1'b0, 64'h0, 1'b1, 1'b1, 24'h080706, 1'b0};
        tbl[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 24'h0B0A09, 1'b1};
        tbl[6] = '{1'b0, 64'h0, 1'b1, 1'b1, 24'h0E0D0C, 1'b1};
        tbl[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 24'h000000, 1'b1};

        // Directed vectors
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl_mm2s_ready", mm2s_ready, tbl[i].erdy);
            chk("tbl_pix_valid", pix_valid, tbl[i].ev);
            if (tbl[i].ev) chk("tbl_pix_data", pix_data, ord(tbl[i].ed));
            adv();
        end

        // Flush mid-line: fill to 16 bytes, pop 3 pixels, then sync_clr
        do_reset();
        apply(1'b1, W0, 1'b0, 1'b0); adv();
        apply(1'b1, W1, 1'b0, 1'b0); adv();
        apply(1'b0, 64'h0, 1'b0, 1'b0);
        chk("full_mm2s_ready", mm2s_ready, 1'b0);
        adv();
        repeat (3) begin apply(1'b0, 64'h0, 1'b1, 1'b0); adv(); end
        apply(1'b0, 64'h0, 1'b1, 1'b1);
        chk("preclr_pix_valid", pix_valid, 1'b1);
        adv();
        apply(1'b0, 64'h0, 1'b1, 1'b0);
        chk("clr_pix_valid", pix_valid, 1'b0);
        chk("clr_mm2s_ready", mm2s_ready, 1'b1);
        adv();
        apply(1'b1, W2, 1'b1, 1'b0); adv();
        apply(1'b0, 64'h0, 1'b1, 1'b0);
        chk("clr_resume_valid", pix_valid, 1'b1);
        chk("clr_resume_sof", pix_sof, 1'b1);
        chk("clr_resume_data", pix_data, ord(24'h121110));
        adv();
        drain(4);

        // Asynchronous reset mid-frame
        do_reset();
        apply(1'b1, W0, 1'b1, 1'b0); adv();
        apply(1'b1, W1, 1'b1, 1'b0); adv();
        apply(1'b0, 64'h0, 1'b1, 1'b0);
        #2;
        do_reset();
        apply(1'b1, W2, 1'b1, 1'b0); adv();
        apply(1'b0, 64'h0, 1'b1, 1'b0);
        chk("arst_resume_valid", pix_valid, 1'b1);
        chk("arst_resume_sof", pix_sof, 1'b1);
        chk("arst_resume_data", pix_data, ord(24'h121110));
        adv();

        // One full frame, continuous input and output
        do_reset();
        stream(6, 100, 100, 1'b1);
        drain(12);
        chk("frame_n_sof", n_sof, 1);
        chk("frame_n_eol", n_eol, 2);
        chk("frame_n_eof", n_eof, 1);
        chk("frame_n_done", n_fd, 1);
        @(negedge clk);
        chk("frame_end_valid", pix_valid, 1'b0);
        chk("frame_end_ready", mm2s_ready, 1'b1);
        adv();

        // Random traffic with back-pressure on both sides
        do_reset();
        stream(300, 60, 60, 1'b0);
        drain(20);
        chk("rand_n_eof", n_eof, 50);
        chk("rand_n_done", n_fd, 50);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
